// File: rtl/cpu_pkg.sv
// Shared types and defaults for the instruction prefetch path.
//   instr_t    : one instruction word
//   iaddr_t    : one instruction word address
//   pf_state_e : prefetch unit run state
//   *_DEF      : default widths and reset fetch address
package cpu_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    typedef logic [DATA_W_DEF-1:0] instr_t;
    typedef logic [ADDR_W_DEF-1:0] iaddr_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pf_state_e;

endpackage

// File: rtl/instr_prefetch_unit_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy flags.
// Ports:
//   i_clk, i_resetn      clock, async active-low reset
//   i_push, i_data       write one entry (ignored when full)
//   i_pop                drop the head entry (ignored when empty)
//   i_flush              discard all entries; wins over push and pop
//   o_data               head entry
//   o_count              occupancy
//   o_full, o_empty      occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: PC generation, credit-based instruction read issue,
// in-order response queue and branch-redirect flush.
// Ports:
//   i_clk, i_resetn             clock, async active-low reset
//   i_fetch_en                  leave IDLE and start fetching
//   i_halt                      suppress new issues
//   i_redirect, i_redirect_pc   taken branch and its target
//   o_mem_ren, o_mem_radrs      instruction read request
//   i_mem_rvalid, i_mem_rdata   in-order read responses
//   o_out_valid, i_out_ready    head handshake to the fetch stage
//   o_out_instr, o_out_pc       head instruction and its PC
//   o_full, o_empty, o_count    queue occupancy
//
// state | meaning
// IDLE  | no issue; a redirect only loads the PCs
// RUN   | issuing and accepting responses until reset
module instr_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = 8,
    parameter int                MAX_OUT  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic                       i_fetch_en,
    input  logic                       i_halt,
    input  logic                       i_redirect,
    input  logic [ADDR_W-1:0]          i_redirect_pc,
    output logic                       o_mem_ren,
    output logic [ADDR_W-1:0]          o_mem_radrs,
    input  logic                       i_mem_rvalid,
    input  logic [DATA_W-1:0]          i_mem_rdata,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DATA_W-1:0]          o_out_instr,
    output logic [ADDR_W-1:0]          o_out_pc,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int OUT_W = $clog2(MAX_OUT+1);
    localparam int CR_W  = $clog2(DEPTH+MAX_OUT+1) + 1;

    pf_state_e          r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_resp_pc;
    logic [OUT_W-1:0]   r_outstanding;
    logic [OUT_W-1:0]   r_drop_cnt;

    logic                     w_run;
    logic                     w_issue;
    logic                     w_accept;
    logic                     w_pop;
    logic                     w_flush;
    logic                     w_credit_ok;
    logic [CR_W-1:0]          w_pending;
    logic [CNT_W-1:0]         w_count;
    logic                     w_full;
    logic                     w_empty;
    logic [DATA_W+ADDR_W-1:0] w_fifo_out;

    assign w_run = (r_state == RUN);

    // Slots already promised: queued entries plus reads that will be kept.
    // Reads marked for dropping never land in the queue, so they hold no slot.
    assign w_pending   = CR_W'(w_count) + CR_W'(r_outstanding) - CR_W'(r_drop_cnt);
    assign w_credit_ok = (r_outstanding < OUT_W'(MAX_OUT)) && (w_pending < CR_W'(DEPTH));

    assign w_issue  = w_run && !i_halt && !i_redirect && w_credit_ok;
    assign w_accept = w_run && i_mem_rvalid && !i_redirect && (r_drop_cnt == '0);
    assign w_flush  = w_run && i_redirect;
    assign w_pop    = !w_empty && i_out_ready;

    assign o_mem_ren   = w_issue;
    assign o_mem_radrs = w_issue ? r_fetch_pc : '0;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_fetch_en) begin
                        r_state <= RUN;
                    end
                    if (i_redirect) begin
                        r_fetch_pc <= i_redirect_pc;
                        r_resp_pc  <= i_redirect_pc;
                    end
                end
                RUN: begin
                    r_outstanding <= r_outstanding + OUT_W'(w_issue) - OUT_W'(i_mem_rvalid);
                    if (i_redirect) begin
                        r_fetch_pc <= i_redirect_pc;
                        r_resp_pc  <= i_redirect_pc;
                        // A response landing this cycle is already thrown away.
                        r_drop_cnt <= r_outstanding - OUT_W'(i_mem_rvalid);
                    end else begin
                        if (w_issue) begin
                            r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                        end
                        if (w_accept) begin
                            r_resp_pc <= r_resp_pc + ADDR_W'(1);
                        end
                        if (i_mem_rvalid && (r_drop_cnt != '0)) begin
                            r_drop_cnt <= r_drop_cnt - OUT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_push   (w_accept),
        .i_pop    (w_pop),
        .i_flush  (w_flush),
        .i_data   ({i_mem_rdata, r_resp_pc}),
        .o_data   (w_fifo_out),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign o_out_valid = !w_empty;
    assign o_out_instr = w_fifo_out[ADDR_W +: DATA_W];
    assign o_out_pc    = w_fifo_out[ADDR_W-1:0];
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_count     = w_count;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_en;
    logic        halt;
    logic        redirect;
    logic [10:0] redirect_pc;
    logic        mem_ren;
    logic [10:0] mem_radrs;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [10:0] out_pc;
    logic        full;
    logic        empty;
    logic [3:0]  count;

    int          checks = 0;
    int          errors = 0;
    int          seen;
    logic [10:0] exp_pc;
    logic [1:0]  lat_sel;   // memory latency minus one

    always #5 clk = ~clk;

    instr_prefetch_unit dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_fetch_en    (fetch_en),
        .i_halt        (halt),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_mem_ren     (mem_ren),
        .o_mem_radrs   (mem_radrs),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_instr   (out_instr),
        .o_out_pc      (out_pc),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count)
    );

    function automatic logic [31:0] mem_word(input logic [10:0] a);
        return {16'hC0DE, 5'h00, a};
    endfunction

    // In-order memory with a selectable fixed latency of 1..4 cycles.
    logic [3:0]  pv;
    logic [10:0] pa [4];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pv <= '0;
            for (int i = 0; i < 4; i++) pa[i] <= '0;
        end else begin
            pv    <= {pv[2:0], mem_ren};
            pa[3] <= pa[2];
            pa[2] <= pa[1];
            pa[1] <= pa[0];
            pa[0] <= mem_radrs;
        end
    end
    assign mem_rvalid = pv[lat_sel];
    assign mem_rdata  = mem_word(pa[lat_sel]);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_ren"},   64'(mem_ren),   64'd0);
        check({tag, "_mem_radrs"}, 64'(mem_radrs), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
        check({tag, "_out_pc"},    64'(out_pc),    64'd0);
        check({tag, "_full"},      64'(full),      64'd0);
        check({tag, "_empty"},     64'(empty),     64'd1);
        check({tag, "_count"},     64'(count),     64'd0);
    endtask

    // Called at a negedge with out_ready=1: checks the current head (which the
    // next posedge consumes) then moves to the next negedge, n times.
    task automatic stream(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (out_valid) begin
                check({tag, "_pc"},    64'(out_pc),    64'(exp_pc));
                check({tag, "_instr"}, 64'(out_instr), 64'(mem_word(exp_pc)));
                exp_pc = exp_pc + 11'd1;
                seen++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        resetn = 1'b1; fetch_en = 1'b0; halt = 1'b0; redirect = 1'b0;
        redirect_pc = '0; out_ready = 1'b1; lat_sel = 2'd0;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        resetn = 1'b1;
        @(negedge clk); #1;
        check("idle_no_issue", 64'(mem_ren), 64'd0);

        // Streaming, latency 1
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0; #1;
        check("first_ren",   64'(mem_ren),   64'd1);
        check("first_radrs", 64'(mem_radrs), 64'd0);
        check("first_nvld",  64'(out_valid), 64'd0);
        @(negedge clk);
        check("resp_nvld", 64'(out_valid), 64'd0);
        check("outst_1",   64'(dut.r_outstanding), 64'd1);
        @(negedge clk);
        exp_pc = 11'd0; seen = 0;
        stream("stream", 10);
        check("stream_seen",  64'(seen),  64'd10);
        check("stream_count", 64'(count), 64'd1);
        check("stream_outst", 64'(dut.r_outstanding), 64'd1);

        // Backpressure
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("bp_count", 64'(count),   64'd8);
        check("bp_full",  64'(full),    64'd1);
        check("bp_empty", 64'(empty),   64'd0);
        check("bp_ren",   64'(mem_ren), 64'd0);
        check("bp_outst", 64'(dut.r_outstanding), 64'd0);
        out_ready = 1'b1;
        seen = 0;
        stream("bp_drain", 16);
        check("bp_seen", 64'(seen), 64'd16);

        // Halt for 5 cycles: no issue, queue keeps draining
        halt = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            #1 check("halt_ren", 64'(mem_ren), 64'd0);
            stream("halt", 1);
        end
        check("halt_seen", 64'(seen), 64'd5);
        halt = 1'b0;
        stream("resume", 6);

        // Quiesce, then switch memory to latency 3
        halt = 1'b1;
        stream("quiesce", 10);
        check("quiesce_empty", 64'(empty), 64'd1);
        lat_sel = 2'd2;
        halt = 1'b0;
        stream("lat3", 8);
        check("lat3_outst", 64'(dut.r_outstanding), 64'd3);
        check("lat3_count", 64'(count), 64'd1);
        check("lat3_rvld",  64'(out_valid), 64'd1);

        // Redirect with 3 in flight, a response and a dequeue in the same cycle
        redirect = 1'b1; redirect_pc = 11'h100;
        @(negedge clk);
        redirect = 1'b0; #1;
        check("rd_count", 64'(count),            64'd0);
        check("rd_empty", 64'(empty),            64'd1);
        check("rd_nvld",  64'(out_valid),        64'd0);
        check("rd_drop",  64'(dut.r_drop_cnt),   64'd2);
        check("rd_ren",   64'(mem_ren),          64'd1);
        check("rd_radrs", 64'(mem_radrs),        64'h100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rd_gap_nvld", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check("rd_first_vld", 64'(out_valid), 64'd1);
        exp_pc = 11'h100; seen = 0;
        stream("rd_stream", 8);
        check("rd_seen", 64'(seen), 64'd8);

        // Reset mid-stream
        resetn = 1'b0; #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        resetn = 1'b1; lat_sel = 2'd0;
        @(negedge clk); #1;
        check("postrst_ren", 64'(mem_ren), 64'd0);

        // Redirect in IDLE loads the PCs; then wrap-around 0x7FE..0x001
        redirect = 1'b1; redirect_pc = 11'h7FE; #1;
        check("idle_rd_ren", 64'(mem_ren), 64'd0);
        @(negedge clk);
        redirect = 1'b0; #1;
        check("idle_rd_ren2", 64'(mem_ren),   64'd0);
        check("idle_rd_nvld", 64'(out_valid), 64'd0);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0; #1;
        check("wrap_ren",   64'(mem_ren),   64'd1);
        check("wrap_radrs", 64'(mem_radrs), 64'h7FE);
        exp_pc = 11'h7FE; seen = 0;
        stream("wrap", 6);
        check("wrap_seen", 64'(seen), 64'd4);
        check("wrap_next", 64'(exp_pc), 64'h002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
